peripheral_io_ctrl: RTL and testbench
=====================================

# peripheral_io_ctrl

Parametrised operand-entry and result-display controller for the board I/O path. It collects NOPS operands of OPW bits, one byte per debounced-edge press of `enter`, from the 8-bit switch bank into packed operand registers, and raises `inputdata_ready` when all operands are loaded. In result mode it steps through the bytes of `dataR` on four 7-segment digits. It sits between the board pins and the arithmetic datapath, replacing the fixed two-operand, 32-bit peripheral unit.

## Interface
- `OPW`, 32: operand width in bits; multiple of 8, range 8..128; BPO = OPW/8.
- `NOPS`, 2: number of operands, range 1..4.
- `RESW`, 32: result width in bits; multiple of 8, range 8..128; RBY = RESW/8.
- `SCROLL_CYCLES`, 50_000_000: autoscroll period in clk cycles; used only with `PERIPH_AUTOSCROLL_EN`.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enter` in 1: raw push-button, asynchronous to `clk`.
- `loaddata` in 1: 1 = entry mode, 0 = result mode; level, synchronous.
- `inputdata` in 8: switch byte.
- `dataR` in RESW: result from the datapath.
- `inputdata_ready` out 1: all operands loaded.
- `operands` out NOPS*OPW: operand k occupies `[k*OPW +: OPW]`; operand 0 is "A".
- `disp3`..`disp0` out 7 each: active-low segments {g,f,e,d,c,b,a}; hex glyphs 0-F.

## Operation
- Enter conditioning: two-flop synchroniser, then a third flop for edge detection. `enter_p` = stage2 & ~stage3. A held button produces exactly one pulse.
- Registers:
  - `state` ∈ {LOAD, READY, SHOW}.
  - `op_i` (2 b): operand index.
  - `b_i` (4 b): byte index, counting down from BPO-1 to 0, so MSB is entered first.
  - `r_i` (4 b): result byte index.
  - Operand registers.
- LOAD:
  - On `enter_p`, write `inputdata` to operand `op_i`, byte `b_i`.
  - If `b_i` > 0, then `b_i`--.
  - Otherwise `b_i` ← BPO-1. If `op_i` = NOPS-1, go to READY; else `op_i`++.
- READY:
  - `inputdata_ready` = 1.
  - `enter_p` is ignored.
- Any state with `loaddata` = 0: go to SHOW with `r_i` ← RBY-1; `inputdata_ready` ← 0.
- SHOW:
  - `enter_p` decrements `r_i`, wrapping from 0 to RBY-1.
  - `loaddata` = 1 returns to LOAD with `op_i` ← 0 and `b_i` ← BPO-1.
  - Operand registers keep their contents and are overwritten byte by byte on re-entry.
- If `loaddata` drops in the middle of an entry, the partial entry is abandoned. Bytes already written stay in place, and the next entry restarts at operand 0.
- Simultaneous events: a mode change caused by `loaddata` has priority, and an `enter_p` in the same cycle is discarded.
- Displays, combinational from registered state and inputs:
  - LOAD/READY: `disp3` = hex(0xA+`op_i`), showing A-D; `disp2` = hex(`b_i`); `disp1`/`disp0` = live `inputdata[7:4]`/`[3:0]`.
  - SHOW: `disp3` = hex(0xE); `disp2` = hex(`r_i`); `disp1`/`disp0` = `dataR[r_i*8 +: 8]` nibbles.
  - In READY, `disp3`/`disp2` show the wrapped indices (A, BPO-1).

## Timing
- Reset values:
  - `state` = LOAD, `op_i` = 0, `b_i` = BPO-1, `r_i` = RBY-1, sync flops = 0.
  - `operands` = 0 and `inputdata_ready` = 0.
  - Displays follow the state: `disp3` = A, `disp2` = BPO-1, `disp1`/`disp0` = `inputdata`.
- If `loaddata` = 0 after reset, SHOW is entered one edge later.
- Enter latency: with `enter` first sampled high at edge k, `enter_p` is high during the cycle after edge k+1. The operand write and index update are visible after edge k+2.
- `inputdata_ready` rises on the same edge that writes the final byte.
- Mode switch takes effect on the first edge that samples the new `loaddata`.
- `inputdata` is sampled on the write edge, so it must be stable for 3 cycles after the press.
- `reset` during entry discards all progress on that edge.

## Configuration
- `PERIPH_AUTOSCROLL_EN` defined:
  - In SHOW, a counter advances `r_i` (same wrap rule) every SCROLL_CYCLES clocks.
  - The counter clears on entry to SHOW, on `enter_p` (which still steps `r_i` immediately), and on reset.
- Not defined: no counter is built, `r_i` moves only on `enter_p`, and `SCROLL_CYCLES` is unused.

## Test plan
- Reset with `loaddata` = 1, `inputdata` = 8'h5C:
  - Expect `operands` = 0 and `inputdata_ready` = 0.
  - Expect displays A,3,5,C.
- Eight presses with bytes 12,34,56,78,9A,BC,DE,F0:
  - Expect `operands[31:0]` = 32'h12345678 and `operands[63:32]` = 32'h9ABCDEF0.
  - Expect `inputdata_ready` = 1 on the eighth write edge, and a ninth press changes nothing.
- `enter` held high for 100 cycles → exactly one byte written.
- `loaddata` = 0, `dataR` = 32'hCAFEF00D:
  - Expect displays E,3,C,A.
  - Four presses → E,2,F,E; E,1,F,0; E,0,0,D; E,3,C,A.
- Three bytes entered, then `loaddata` 1→0→1, then one press of 8'hFF → `operands[31:24]` = 8'hFF, with bytes 2..1 still holding the earlier values.
- With `PERIPH_AUTOSCROLL_EN`, SCROLL_CYCLES = 10, in SHOW → `r_i` steps 3→2 after 10 cycles; a press at cycle 5 steps it immediately and restarts the count.

Source files
------------

// File: rtl/peripheral_io_ctrl.sv
// Operand-entry / result-display controller: collects NOPS operands of OPW bits byte by byte
// from the switch bank and scrolls result bytes on four 7-segment digits. Optional macro: PERIPH_AUTOSCROLL_EN.
module peripheral_io_ctrl #(
    parameter int OPW           = 32,
    parameter int NOPS          = 2,
    parameter int RESW          = 32,
    parameter int SCROLL_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enter,
    input  logic                 loaddata,
    input  logic [7:0]           inputdata,
    input  logic [RESW-1:0]      dataR,
    output logic                 inputdata_ready,
    output logic [NOPS*OPW-1:0]  operands,
    output logic [6:0]           disp3,
    output logic [6:0]           disp2,
    output logic [6:0]           disp1,
    output logic [6:0]           disp0
);

    localparam int BPO = OPW / 8;
    localparam int RBY = RESW / 8;
    localparam logic [3:0] B_TOP  = 4'(BPO - 1);
    localparam logic [3:0] R_TOP  = 4'(RBY - 1);
    localparam logic [1:0] OP_TOP = 2'(NOPS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                state_r;
    logic [1:0]            op_i_r;
    logic [3:0]            b_i_r;
    logic [3:0]            r_i_r;
    logic                  ready_r;
    logic [NOPS*OPW-1:0]   operands_r;
    logic                  sync1_r;
    logic                  sync2_r;
    logic                  sync3_r;
    logic                  enter_p_s;
    logic                  scroll_tick_s;
    logic [7:0]            res_byte_s;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0-F.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Result index steps downwards and wraps from 0 back to the top byte.
    function automatic logic [3:0] r_dec(input logic [3:0] r);
        logic [3:0] nxt;
        if (r == 4'd0) begin
            nxt = R_TOP;
        end else begin
            nxt = r - 4'd1;
        end
        return nxt;
    endfunction

    // Button synchroniser plus edge-detect stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= enter;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign enter_p_s = sync2_r & ~sync3_r;

`ifdef PERIPH_AUTOSCROLL_EN
    localparam int SCW = $clog2(SCROLL_CYCLES + 1);
    logic [SCW-1:0] scroll_cnt_r;

    assign scroll_tick_s = (state_r == ST_SHOW) && (scroll_cnt_r == SCW'(SCROLL_CYCLES - 1));

    // Autoscroll period counter; held clear outside SHOW so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_cnt_r <= '0;
        end else if ((state_r != ST_SHOW) || enter_p_s || scroll_tick_s) begin
            scroll_cnt_r <= '0;
        end else begin
            scroll_cnt_r <= scroll_cnt_r + SCW'(1);
        end
    end
`else
    // Without autoscroll the period parameter has no effect.
    assign scroll_tick_s = 1'b0 & (SCROLL_CYCLES > 0);
`endif

    // Mode FSM, operand capture and index bookkeeping; loaddata changes win over a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_LOAD;
            op_i_r     <= 2'd0;
            b_i_r      <= B_TOP;
            r_i_r      <= R_TOP;
            ready_r    <= 1'b0;
            operands_r <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (!loaddata) begin
                        state_r <= ST_SHOW;
                        r_i_r   <= R_TOP;
                        ready_r <= 1'b0;
                    end else if (enter_p_s) begin
                        for (int k = 0; k < NOPS; k++) begin
                            for (int j = 0; j < BPO; j++) begin
                                if ((op_i_r == 2'(k)) && (b_i_r == 4'(j))) begin
                                    operands_r[k*OPW + j*8 +: 8] <= inputdata;
                                end
                            end
                        end
                        if (b_i_r != 4'd0) begin
                            b_i_r <= b_i_r - 4'd1;
                        end else begin
                            b_i_r <= B_TOP;
                            if (op_i_r == OP_TOP) begin
                                state_r <= ST_READY;
                                op_i_r  <= 2'd0;
                                ready_r <= 1'b1;
                            end else begin
                                op_i_r <= op_i_r + 2'd1;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (!loaddata) begin
                        state_r <= ST_SHOW;
                        r_i_r   <= R_TOP;
                        ready_r <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (loaddata) begin
                        state_r <= ST_LOAD;
                        op_i_r  <= 2'd0;
                        b_i_r   <= B_TOP;
                    end else if (enter_p_s || scroll_tick_s) begin
                        r_i_r <= r_dec(r_i_r);
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                    op_i_r  <= 2'd0;
                    b_i_r   <= B_TOP;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign res_byte_s      = dataR[{r_i_r, 3'b000} +: 8];
    assign inputdata_ready = ready_r;
    assign operands        = operands_r;

    // Digit drivers: indices plus live switches in entry, selected result byte in SHOW.
    always_comb begin
        disp3 = hex7(4'hA + {2'b00, op_i_r});
        disp2 = hex7(b_i_r);
        disp1 = hex7(inputdata[7:4]);
        disp0 = hex7(inputdata[3:0]);
        case (state_r)
            ST_SHOW: begin
                disp3 = hex7(4'hE);
                disp2 = hex7(r_i_r);
                disp1 = hex7(res_byte_s[7:4]);
                disp0 = hex7(res_byte_s[3:0]);
            end
            ST_LOAD, ST_READY: begin
                disp3 = hex7(4'hA + {2'b00, op_i_r});
                disp2 = hex7(b_i_r);
            end
            default: begin
                disp3 = hex7(4'hA);
                disp2 = hex7(B_TOP);
            end
        endcase
    end

endmodule

// File: tb/tb_peripheral_io_ctrl.sv
// Directed plus randomized bench for peripheral_io_ctrl against a byte-count reference model.
module tb_peripheral_io_ctrl;

    localparam int OPW   = 32;
    localparam int NOPS  = 2;
    localparam int RESW  = 32;
    localparam int SC    = 10;
    localparam int BPO   = OPW / 8;
    localparam int RBY   = RESW / 8;
    localparam int TOTAL = NOPS * BPO;
`ifdef PERIPH_AUTOSCROLL_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif
    localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic                clk = 1'b0;
    logic                reset;
    logic                enter;
    logic                loaddata;
    logic [7:0]          inputdata;
    logic [RESW-1:0]     dataR;
    logic                inputdata_ready;
    logic [NOPS*OPW-1:0] operands;
    logic [6:0]          disp3, disp2, disp1, disp0;

    int vecs = 0;
    int errs = 0;

    // model: bytes entered so far, result presses, scroll counter, mode
    int         m_n, m_p, m_scroll;
    bit         m_ld;
    logic [7:0] mem [TOTAL];

    peripheral_io_ctrl #(.OPW(OPW), .NOPS(NOPS), .RESW(RESW), .SCROLL_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .enter(enter), .loaddata(loaddata),
        .inputdata(inputdata), .dataR(dataR), .inputdata_ready(inputdata_ready),
        .operands(operands), .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        return ~SEG_ON[v];
    endfunction

    function automatic logic [NOPS*OPW-1:0] exp_ops();
        logic [NOPS*OPW-1:0] v;
        v = '0;
        for (int k = 0; k < NOPS; k++)
            for (int j = 0; j < BPO; j++)
                v[k*OPW + j*8 +: 8] = mem[k*BPO + j];
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int op, b, r;
        logic [7:0] rb;
        logic [6:0] e3, e2, e1, e0;
        if (m_ld) begin
            if (m_n >= TOTAL) begin op = 0; b = BPO - 1; end
            else begin op = m_n / BPO; b = BPO - 1 - (m_n % BPO); end
            e3 = glyph(10 + op);
            e2 = glyph(b);
            e1 = glyph(int'(inputdata[7:4]));
            e0 = glyph(int'(inputdata[3:0]));
        end else begin
            r  = RBY - 1 - (m_p % RBY);
            rb = 8'(dataR >> (8 * r));
            e3 = glyph(14);
            e2 = glyph(r);
            e1 = glyph(int'(rb[7:4]));
            e0 = glyph(int'(rb[3:0]));
        end
        check({tag, ".operands"}, 128'(operands), 128'(exp_ops()));
        check({tag, ".ready"}, 128'(inputdata_ready), (m_ld && m_n == TOTAL) ? 128'd1 : 128'd0);
        check({tag, ".disp3"}, 128'(disp3), 128'(e3));
        check({tag, ".disp2"}, 128'(disp2), 128'(e2));
        check({tag, ".disp1"}, 128'(disp1), 128'(e1));
        check({tag, ".disp0"}, 128'(disp0), 128'(e0));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (SC_EN && !m_ld) begin
                m_scroll++;
                if (m_scroll == SC) begin m_p++; m_scroll = 0; end
            end
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_p = 0; m_scroll = 0; m_ld = loaddata;
        for (int i = 0; i < TOTAL; i++) mem[i] = 8'h00;
    endtask

    task automatic apply_press(input logic [7:0] v);
        int op, b;
        if (m_ld) begin
            if (m_n < TOTAL) begin
                op = m_n / BPO;
                b  = BPO - 1 - (m_n % BPO);
                mem[op*BPO + b] = v;
                m_n++;
            end
        end else begin
            m_p++;
            m_scroll = 0;
        end
    endtask

    // enter high for three edges: write lands on the third, then release
    task automatic press(input logic [7:0] v);
        inputdata = v;
        enter = 1'b1;
        step(2);
        @(negedge clk);
        apply_press(v);
        check_all("press");
        enter = 1'b0;
        step(3);
    endtask

    task automatic set_mode(input logic v);
        loaddata = v;
        if (!v && m_ld) begin
            step(1);
            m_ld = 1'b0; m_n = 0; m_p = 0; m_scroll = 0;
        end else if (v && !m_ld) begin
            m_ld = 1'b1;
            step(1);
            m_n = 0;
        end else begin
            step(1);
        end
        check_all("mode");
    endtask

    initial begin
        logic [7:0] seq [8];
        logic [7:0] b1, b2, b3;
        logic [NOPS*OPW-1:0] snap;
        seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        reset = 1'b1; enter = 1'b0; loaddata = 1'b1; inputdata = 8'h5C; dataR = '0;
        m_ld = 1'b1;
        step(2);
        reset = 1'b0;
        model_reset();
        check_all("reset");
        check("rst_disp3", 128'(disp3), 128'(7'h08));
        check("rst_disp2", 128'(disp2), 128'(7'h30));
        check("rst_disp1", 128'(disp1), 128'(7'h12));
        check("rst_disp0", 128'(disp0), 128'(7'h46));

        for (int i = 0; i < 8; i++) press(seq[i]);
        check("eight_ops", 128'(operands), 128'(64'h9ABCDEF0_12345678));
        check("eight_ready", 128'(inputdata_ready), 128'd1);
        snap = operands;
        press(8'h77);
        check("ninth_ignored", 128'(operands), 128'(snap));

        // long hold yields one byte only
        set_mode(1'b0);
        set_mode(1'b1);
        inputdata = 8'hA5;
        enter = 1'b1;
        step(2);
        @(negedge clk);
        apply_press(8'hA5);
        step(97);
        enter = 1'b0;
        step(3);
        check_all("held");
        check("held_byte", 128'(operands[31:24]), 128'(8'hA5));

        dataR = 32'hCAFEF00D;
        set_mode(1'b0);
        check("show_d3", 128'(disp3), 128'(7'h06));
        check("show_d2", 128'(disp2), 128'(7'h30));
        check("show_d1", 128'(disp1), 128'(7'h46));
        check("show_d0", 128'(disp0), 128'(7'h08));
        for (int i = 0; i < 4; i++) press(8'h00);
        check("wrap_d2", 128'(disp2), 128'(7'h30));
        check("wrap_d1", 128'(disp1), 128'(7'h46));

        // abandoned entry restarts at operand A, earlier bytes stay
        set_mode(1'b1);
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        press(b1); press(b2); press(b3);
        set_mode(1'b0);
        set_mode(1'b1);
        press(8'hFF);
        check("abandon_top", 128'(operands[31:24]), 128'(8'hFF));
        check("abandon_mid", 128'(operands[23:8]), 128'({b2, b3}));

        press(8'h3C); press(8'hC3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_reset();
        check_all("mid_reset");
        check("mid_reset_ops", 128'(operands), 128'd0);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: press(8'($urandom));
                6: set_mode(~loaddata);
                7: begin dataR = RESW'($urandom); #1; check_all("rnd_data"); end
                8: begin inputdata = 8'($urandom); #1; check_all("rnd_sw"); end
                default: begin step($urandom_range(1, 4)); check_all("rnd_idle"); end
            endcase
        end

        set_mode(1'b1);
        set_mode(1'b0);
`ifdef PERIPH_AUTOSCROLL_EN
        step(9);
        check("scroll_hold", 128'(disp2), 128'(7'h30));
        step(1);
        check("scroll_step", 128'(disp2), 128'(7'h24));
        check_all("scroll");
        step(2);
        enter = 1'b1;
        step(2);
        @(negedge clk);
        apply_press(8'h00);
        check("scroll_press", 128'(disp2), 128'(7'h79));
        enter = 1'b0;
        step(9);
        check("scroll_restart", 128'(disp2), 128'(7'h79));
        step(1);
        check("scroll_next", 128'(disp2), 128'(7'h40));
        check_all("scroll_end");
`else
        step(25);
        check("no_scroll", 128'(disp2), 128'(7'h30));
        check_all("no_scroll");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
